logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the combinational gate set.
- WIDTH-bit bitwise logic unit; 3-bit opcode selects AND/OR/NOT/NAND/NOR/XOR/XNOR or XOR-accumulate.
- Operands and results move on valid/ready handshakes through one output register stage with backpressure.
- Sits between an operand source and a consumer in the datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1)

Ports:
- clk  input  1  single system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit can accept a beat this cycle
- op  input  3  opcode, sampled with the beat
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B; ignored for NOT and ACC
- acc_clr  input  1  synchronous clear of the accumulator
- out_valid  output  1  result register holds an unconsumed result
- out_ready  input  1  consumer accepts the result
- y  output  WIDTH  result
- zero  output  1  y == 0
- parity  output  1  XOR-reduction of y

Behaviour:
- Interface: one clock domain, clk; reset rst_n is asynchronous and active-low.
- Reset (async on rst_n low): out_valid=0, y=0, zero=1, parity=0, acc=0. This holds while rst_n is low; release is synchronous to clk.
- Accept condition: in_fire = in_valid && in_ready.
- Output handshake: out_fire = out_valid && out_ready.
- Ready rule: in_ready = !out_valid || out_ready (combinational). Full throughput is one beat per cycle.
- Latency: 1 cycle. The result is registered on the clk edge where in_fire=1, and out_valid=1 from the next cycle.
- Opcodes and results:
  - 0 AND = a&b
  - 1 OR = a|b
  - 2 NOT = ~a
  - 3 NAND = ~(a&b)
  - 4 NOR = ~(a|b)
  - 5 XOR = a^b
  - 6 XNOR = ~(a^b)
  - 7 ACC = acc^a
- ACC update: on in_fire with op=7, acc <= acc^a. acc changes only on an op=7 fire or on acc_clr.
- acc_clr alone: acc <= 0 at the next edge. An in-flight y is not affected.
- acc_clr together with an op=7 in_fire: the clear takes priority for the source. Result y = a, and acc <= a.
- acc_clr together with a non-ACC fire: acc <= 0; y is the normal result.
- out_valid next-state:
  - in_fire → 1
  - else out_fire → 0
  - else hold
- Stall (out_valid=1, out_ready=0): y, zero, parity and out_valid hold stable; in_ready=0. A presented beat must wait; acc is not updated by a non-accepted beat.
- Simultaneous out_fire and in_fire: the new result replaces the old in the same edge, with no bubble.
- zero and parity are registered alongside y, so they are always consistent with y.
- Reset mid-operation: a pending result is dropped (out_valid=0) and acc is cleared. No beat is accepted while rst_n is low.
- Width: all ops are bitwise, with no carries. WIDTH=1 must work; parity then equals y.

Decomposition:
- Shared package logic_unit_pkg:
  - opcode localparams OP_AND=0, OP_OR=1, OP_NOT=2, OP_NAND=3, OP_NOR=4, OP_XOR=5, OP_XNOR=6, OP_ACC=7
  - a function computing the result for a given op, a, b, acc
- Sub-module logic_unit_core:
  - purely combinational; op, a, b, acc_src → result
  - reused by future multi-lane variants
- The top holds the handshake, the output register and the acc register.

Test Plan (WIDTH=8):
- Reset and first beat: assert rst_n=0 mid-stream with out_valid=1 → out_valid=0, y=0, zero=1, acc=0 immediately; after release in_ready=1.
- Full opcode sweep with out_ready=1: a=0xC5, b=0x3A, op 0..6 on consecutive beats.
  - Expected y: 0x00, 0xFF, 0x3A, 0xFF, 0x00, 0xFF, 0x00, one cycle after each fire.
  - zero=1 on the 0x00 results; parity=0 on all results.
- Backpressure: out_ready=0 for 3 cycles after a fire of AND a=0xF0, b=0x3C (y=0x30).
  - y held at 0x30 and in_ready=0 throughout.
  - A pending XOR beat is accepted only in the cycle out_ready rises; y=0xCC on the next cycle.
- Accumulate: op=7 beats with a=0x01, 0x02, 0x04 → y=0x01, 0x03, 0x07.
  - Then acc_clr=1 with op=7, a=0x80 → y=0x80; next op=7 beat a=0x01 → y=0x81.
- acc_clr alone while y=0x07 is held under a stall → y stays 0x07; next op=7 beat a=0x10 → y=0x10.
- Back-to-back throughput: in_valid=1 and out_ready=1 for 16 random beats → 16 results on 16 consecutive cycles, no bubbles, each matching the core model.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared opcode encodings and the per-bit result function for the bitwise logic unit.
package logic_unit_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_ACC  = 3'd7;

  // Every op is bitwise, so one bit-slice function serves any operand width.
  function automatic logic lu_bit(input logic [2:0] op, input logic a, input logic b,
                                  input logic acc);
    logic r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOT:  r = ~a;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      default: r = acc ^ a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_core.sv
// Combinational WIDTH-bit logic core: op, a, b and the accumulator source give the result.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc_src,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      result[i] = lu_bit(op, a[i], b[i], acc_src[i]);
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with valid/ready handshakes, one output stage and an XOR accumulator.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_src;
  logic [WIDTH-1:0] result;
  logic             in_fire;
  logic             out_fire;

  assign in_ready = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // A same-cycle clear wins over the stored value, so ACC then yields plain a.
  assign acc_src = acc_clr ? '0 : acc;

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .op      (op),
    .a       (a),
    .b       (b),
    .acc_src (acc_src),
    .result  (result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (in_fire && op == OP_ACC) begin
      acc <= result;
    end else if (acc_clr) begin
      acc <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      zero      <= 1'b1;
      parity    <= 1'b0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      y         <= result;
      zero      <= (result == '0);
      parity    <= ^result;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe (WIDTH=8): vector table plus backpressure, accumulate and reset sequences.
module tb_logic_unit_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       acc_clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       zero;
  logic       parity;

  int n_cmp;
  int n_err;

  logic_unit_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .zero      (zero),
    .parity    (parity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       clr;
    logic [7:0] y;
    logic       z;
    logic       p;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] av,
                       input logic [7:0] bv, input logic c, input logic rdy);
    in_valid  = v;
    op        = o;
    a         = av;
    b         = bv;
    acc_clr   = c;
    out_ready = rdy;
  endtask

  function automatic logic [7:0] model(input logic [2:0] o, input logic [7:0] av,
                                       input logic [7:0] bv, input logic [7:0] accv);
    case (o)
      3'd0: return av & bv;
      3'd1: return av | bv;
      3'd2: return ~av;
      3'd3: return ~(av & bv);
      3'd4: return ~(av | bv);
      3'd5: return av ^ bv;
      3'd6: return ~(av ^ bv);
      default: return accv ^ av;
    endcase
  endfunction

  initial begin
    logic [7:0] acc_m;
    logic [7:0] exp_y;
    int         bubbles;

    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);

    tbl[0]  = '{3'd0, 8'hC5, 8'h3A, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[1]  = '{3'd1, 8'hC5, 8'h3A, 1'b0, 8'hFF, 1'b0, 1'b0};
    tbl[2]  = '{3'd2, 8'hC5, 8'h3A, 1'b0, 8'h3A, 1'b0, 1'b0};
    tbl[3]  = '{3'd3, 8'hC5, 8'h3A, 1'b0, 8'hFF, 1'b0, 1'b0};
    tbl[4]  = '{3'd4, 8'hC5, 8'h3A, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[5]  = '{3'd5, 8'hC5, 8'h3A, 1'b0, 8'hFF, 1'b0, 1'b0};
    tbl[6]  = '{3'd6, 8'hC5, 8'h3A, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[7]  = '{3'd7, 8'h01, 8'hAA, 1'b0, 8'h01, 1'b0, 1'b1};
    tbl[8]  = '{3'd7, 8'h02, 8'hAA, 1'b0, 8'h03, 1'b0, 1'b0};
    tbl[9]  = '{3'd7, 8'h04, 8'hAA, 1'b0, 8'h07, 1'b0, 1'b1};
    tbl[10] = '{3'd7, 8'h80, 8'hAA, 1'b1, 8'h80, 1'b0, 1'b1};
    tbl[11] = '{3'd7, 8'h01, 8'hAA, 1'b0, 8'h81, 1'b0, 1'b0};

    // Reset state
    step();
    step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_y", {24'd0, y}, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    chk("rst_parity", {31'd0, parity}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Opcode sweep and accumulate sequence, one beat per cycle
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].clr, 1'b1);
      step();
      chk($sformatf("tbl%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("tbl%0d_y", i), {24'd0, y}, {24'd0, tbl[i].y});
      chk($sformatf("tbl%0d_zero", i), {31'd0, zero}, {31'd0, tbl[i].z});
      chk($sformatf("tbl%0d_parity", i), {31'd0, parity}, {31'd0, tbl[i].p});
    end
    acc_m = 8'h81;

    // Backpressure: AND result held for 3 stalled cycles, pending XOR waits
    drive(1'b1, 3'd0, 8'hF0, 8'h3C, 1'b0, 1'b1);
    step();
    chk("bp_first_y", {24'd0, y}, 32'h30);
    drive(1'b1, 3'd5, 8'hF0, 8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("bp_hold%0d_y", i), {24'd0, y}, 32'h30);
      chk($sformatf("bp_hold%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
      chk($sformatf("bp_hold%0d_valid", i), {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("bp_xor_y", {24'd0, y}, 32'hCC);
    chk("bp_xor_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    step();
    chk("bp_drain_valid", {31'd0, out_valid}, 32'd0);

    // acc_clr alone during a stall leaves the held y untouched
    drive(1'b1, 3'd7, 8'h07, 8'h00, 1'b1, 1'b1);
    step();
    chk("clr_load_y", {24'd0, y}, 32'h07);
    drive(1'b0, 3'd7, 8'h00, 8'h00, 1'b1, 1'b0);
    step();
    chk("clr_stall_y", {24'd0, y}, 32'h07);
    chk("clr_stall_valid", {31'd0, out_valid}, 32'd1);
    drive(1'b1, 3'd7, 8'h10, 8'h00, 1'b0, 1'b1);
    step();
    chk("clr_after_y", {24'd0, y}, 32'h10);
    acc_m = 8'h10;

    // Back-to-back random beats, no bubbles
    bubbles = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b0, 1'b1);
      #1;
      if (in_ready !== 1'b1) bubbles++;
      exp_y = model(op, a, b, acc_m);
      if (op == 3'd7) acc_m = exp_y;
      step();
      chk($sformatf("b2b%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("b2b%0d_y", i), {24'd0, y}, {24'd0, exp_y});
      chk($sformatf("b2b%0d_zero", i), {31'd0, zero}, {31'd0, exp_y == 8'h00});
      chk($sformatf("b2b%0d_parity", i), {31'd0, parity}, {31'd0, ^exp_y});
    end
    chk("b2b_bubbles", bubbles, 32'd0);

    // Asynchronous reset with a pending result and a beat presented
    drive(1'b1, 3'd1, 8'h5A, 8'h00, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_y", {24'd0, y}, 32'd0);
    chk("mid_rst_zero", {31'd0, zero}, 32'd1);
    chk("mid_rst_parity", {31'd0, parity}, 32'd0);
    step();
    chk("mid_rst_hold_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 3'd7, 8'h05, 8'h00, 1'b0, 1'b1);
    step();
    chk("post_rst_acc_y", {24'd0, y}, 32'h05);
    in_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
